// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between fetch and MEM stage; data has priority.
// Latency: LATENCY+2 cycles per access (request cycle, LATENCY+1 in flight), plus one DONE turnaround.
// Backpressure: stalls the pipeline combinationally until the dependent access completes.
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InstrReqF,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallF,
  output logic        StallM,
  output logic        FlushW,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData
);

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [2:0] {IDLE, DACC, DDONE, FACC, FDONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_vld_q, instr_vld_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        is_load_q, is_load_d;

  logic        dreq;
  logic        stall_m;
  logic        stall_f;

  // A MEM-stage access holds the pipeline until its DDONE cycle; a fetch
  // stalls the front end only while no valid instruction is buffered.
  assign dreq    = MemReadM | MemWriteM;
  assign stall_m = dreq & (state_q != DDONE);
  assign stall_f = stall_m | (InstrReqF & ~instr_vld_q);

  assign StallM      = stall_m;
  assign FlushW      = stall_m;
  assign StallF      = stall_f;
  assign InstrF      = instr_q;
  assign InstrValidF = instr_vld_q;
  assign ReadDataM   = rdata_q;
  assign MemAddr     = addr_q;
  assign MemWData    = wdata_q;
  assign MemWE       = we_q;
  // The strobe is only the first in-flight cycle, while cnt still holds its load value.
  assign MemReq      = ((state_q == DACC) || (state_q == FACC)) && (cnt_q == LAT4);

  // Next-state: grant data before fetch, count down the fixed latency, capture read data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    instr_vld_d = instr_vld_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    is_load_d   = is_load_q;

    // The decode stage takes the buffered instruction whenever the front end advances.
    if (InstrReqF && !stall_f) begin
      instr_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (dreq) begin
          state_d   = DACC;
          addr_d    = ALUOutM;
          wdata_d   = WriteDataM;
          we_d      = MemWriteM;
          is_load_d = MemReadM;
          cnt_d     = LAT4;
        end else if (InstrReqF && !instr_vld_q) begin
          state_d = FACC;
          addr_d  = PCF;
          we_d    = 1'b0;
          cnt_d   = LAT4;
        end
      end
      DACC, FACC: begin
        if (cnt_q == 4'd0) begin
          if (state_q == DACC) begin
            state_d = DDONE;
            // Stores complete silently; the memory's read bus is ignored.
            if (is_load_q) begin
              rdata_d = MemRData;
            end
          end else begin
            state_d     = FDONE;
            instr_d     = MemRData;
            instr_vld_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DDONE, FDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; an in-flight access is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      instr_q     <= 32'd0;
      instr_vld_q <= 1'b0;
      rdata_q     <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      is_load_q   <= is_load_d;
    end
  end

endmodule
